// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution window loader
// Purpose: state encoding, core slot map and default widths shared by the
//   loader, its line buffer and the 3x3 convolution core.
// Ports: none (package).
package conv_pkg;

  localparam int DATA_W_DEF    = 32;  // core data width (core m)
  localparam int ADDR_W_DEF    = 5;   // core address width (core n)
  localparam int PARK_ADDR_DEF = 31;  // idle address, outside slots 0..17
  localparam int KSLOT_BASE    = 9;   // kernel occupies slots 9..17
  localparam int NUM_TAPS      = 9;   // 3x3 window / kernel size

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_K,
    ST_FILL,
    ST_EMIT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - two image-row delay lines feeding a 3x3 window
// Purpose: every shift pushes one raster-order pixel in; the window then holds
//   rows r-2..r and columns c-2..c around the newest pixel (r,c).
// Ports:
//   clk         clock
//   shift_en_i  accept pix_i this cycle
//   pix_i       incoming pixel
//   win_o       nine window words, row-major, index 0 = top-left
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 28
) (
  input  logic                             clk,
  input  logic                             shift_en_i,
  input  logic [DATA_W-1:0]                pix_i,
  output logic [NUM_TAPS-1:0][DATA_W-1:0]  win_o
);

  // line0 oldest entry is pixel (r-1,c), line1 oldest is (r-2,c).
  logic [IMG_W-1:0][DATA_W-1:0] line0_q;
  logic [IMG_W-1:0][DATA_W-1:0] line1_q;
  logic [2:0][2:0][DATA_W-1:0]  win_q;  // [row][col], col 0 is oldest

  // Pixel data carries no reset: nothing is emitted until two full rows and
  // three columns have been shifted in after a frame start.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      line0_q <= {line0_q[IMG_W-2:0], pix_i};
      line1_q <= {line1_q[IMG_W-2:0], line0_q[IMG_W-1]};
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[2][2] <= pix_i;
      win_q[1][2] <= line0_q[IMG_W-1];
      win_q[0][2] <= line1_q[IMG_W-1];
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_o[r*3+c] = win_q[r][c];
      end
    end
  end

endmodule

// File: rtl/conv_window_loader.sv
// rtl/conv_window_loader.sv - streams kernel and image windows into the 3x3 convolution core
// Purpose: writes the kernel into core slots 9..17, then for every valid 3x3
//   window serialises its nine pixels into slots 0..8 and raises res_valid
//   CONV_LAT cycles after slot 8 is written.
// Optional build: define KERNEL_PERSIST_EN to add keep_k, which lets a frame
//   skip the kernel load and reuse the weights already held by the core.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a frame, ignored unless idle
//   keep_k                    (KERNEL_PERSIST_EN only) reuse previous kernel
//   s_data, s_valid, s_ready  kernel words, then raster-order pixels
//   conv_a, conv_addr         core data / address, PARK_ADDR when not writing
//   conv_en                   core enable, high whenever not idle
//   res_valid, res_last       core output valid / final window of the frame
//   busy, done                not idle / one-cycle frame-complete pulse
module conv_window_loader
  import conv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int CONV_LAT  = 10,
  parameter int PARK_ADDR = PARK_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef KERNEL_PERSIST_EN
  input  logic              keep_k,
`endif
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] conv_a,
  output logic [ADDR_W-1:0] conv_addr,
  output logic              conv_en,
  output logic              res_valid,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_e                          state_q;
  logic [3:0]                      tap_q;   // kernel word index in LOAD_K, window tap in EMIT
  logic [COL_W-1:0]                col_q;   // position of the next pixel to arrive
  logic [ROW_W-1:0]                row_q;
  logic [COL_W-1:0]                col_d;
  logic [ROW_W-1:0]                row_d;
  logic                            last_q;  // window being emitted ends the frame
  logic [CONV_LAT-1:0]             vld_q;   // in-flight results, oldest at MSB
  logic [CONV_LAT-1:0]             lst_q;
  logic                            done_q;
  logic                            emit_end;
  logic                            win_ready;
  logic                            shift_en;
  logic [NUM_TAPS-1:0][DATA_W-1:0] win;

  assign shift_en  = (state_q == ST_FILL) && s_valid;
  assign emit_end  = (state_q == ST_EMIT) && (tap_q == 4'(NUM_TAPS-1));
  assign win_ready = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_comb begin
    col_d = col_q + COL_W'(1);
    row_d = row_q;
    if (col_q == COL_W'(IMG_W-1)) begin
      col_d = '0;
      row_d = row_q + ROW_W'(1);
    end
  end

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_line_buffer (
    .clk        (clk),
    .shift_en_i (shift_en),
    .pix_i      (s_data),
    .win_o      (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
      vld_q   <= '0;
      lst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      vld_q  <= {vld_q[CONV_LAT-2:0], emit_end};
      lst_q  <= {lst_q[CONV_LAT-2:0], emit_end && last_q};
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tap_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            last_q  <= 1'b0;
            state_q <= ST_LOAD_K;
`ifdef KERNEL_PERSIST_EN
            if (keep_k) state_q <= ST_FILL;
`endif
          end
        end
        ST_LOAD_K: begin
          if (s_valid) begin
            if (tap_q == 4'(NUM_TAPS-1)) begin
              tap_q   <= '0;
              state_q <= ST_FILL;
            end else begin
              tap_q <= tap_q + 4'd1;
            end
          end
        end
        ST_FILL: begin
          if (s_valid) begin
            col_q <= col_d;
            row_q <= row_d;
            if (win_ready) begin
              tap_q   <= '0;
              last_q  <= (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (emit_end) begin
            tap_q   <= '0;
            state_q <= last_q ? ST_DRAIN : ST_FILL;
          end else begin
            tap_q <= tap_q + 4'd1;
          end
        end
        ST_DRAIN: begin
          // Leave when only the oldest slot can still be occupied, so done
          // lands the cycle right after the final res_valid.
          if (vld_q[CONV_LAT-2:0] == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The core writes every cycle, so any cycle without an intended write
  // must present the park address.
  always_comb begin
    s_ready   = 1'b0;
    conv_addr = ADDR_W'(PARK_ADDR);
    conv_a    = '0;
    case (state_q)
      ST_LOAD_K: begin
        s_ready = 1'b1;
        if (s_valid) begin
          conv_addr = ADDR_W'(KSLOT_BASE) + ADDR_W'(tap_q);
          conv_a    = s_data;
        end
      end
      ST_FILL: s_ready = 1'b1;
      ST_EMIT: begin
        conv_addr = ADDR_W'(tap_q);
        conv_a    = win[tap_q];
      end
      default: ;
    endcase
  end

  assign conv_en   = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = vld_q[CONV_LAT-1];
  assign res_last  = lst_q[CONV_LAT-1];
  assign done      = done_q;

endmodule

// File: tb/tb_conv_window_loader.sv
// tb/tb_conv_window_loader.sv - self-checking bench for conv_window_loader
module tb_conv_window_loader;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int LAT  = 10;
  localparam int NWIN = (H-2)*(W-2);
  localparam logic [AW-1:0] PARK_A = 5'd31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] conv_a;
  logic [AW-1:0] conv_addr;
  logic          conv_en;
  logic          res_valid;
  logic          res_last;
  logic          busy;
  logic          done;
`ifdef KERNEL_PERSIST_EN
  logic          keep_k = 1'b0;
`endif

  always #5 clk = ~clk;

  conv_window_loader #(
    .DATA_W(DW), .ADDR_W(AW), .IMG_W(W), .IMG_H(H), .CONV_LAT(LAT), .PARK_ADDR(31)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef KERNEL_PERSIST_EN
    .keep_k(keep_k),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .conv_a(conv_a), .conv_addr(conv_addr), .conv_en(conv_en),
    .res_valid(res_valid), .res_last(res_last), .busy(busy), .done(done)
  );

  int checks = 0;
  int errs   = 0;

`define CHK(tag, obs, expv) \
  begin \
    checks++; \
    assert ((obs) === (expv)) else begin \
      errs++; \
      $error("FAIL %s: observed=%0d expected=%0d", tag, (obs), (expv)); \
    end \
  end

  // Environment: core register file plus dot product with fixed latency.
  int            cyc = 0;
  logic [DW-1:0] core_mem [18];
  logic [DW-1:0] pend_sum [$];
  int            pend_due [$];
  logic [DW-1:0] got_sum  [$];
  logic          got_last [$];
  int            got_cyc  [$];
  int            done_log [$];
  int            addr_log [$];
  int            runs     [$];
  int            run_len  = 0;
  int            late_err = 0;

  always @(negedge clk) begin
    logic [DW-1:0] acc;
    cyc = cyc + 1;
    if (rst) begin
      pend_sum.delete();
      pend_due.delete();
      run_len = 0;
    end else begin
      if (conv_en && int'(conv_addr) < 18) core_mem[int'(conv_addr)] = conv_a;
      if (conv_addr != PARK_A) addr_log.push_back(int'(conv_addr));
      if (conv_en && conv_addr == AW'(8)) begin
        acc = '0;
        for (int j = 0; j < 9; j++) acc = acc + core_mem[j] * core_mem[9+j];
        pend_sum.push_back(acc);
        pend_due.push_back(cyc + LAT);
      end
      if (res_valid) begin
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
          got_sum.push_back(pend_sum.pop_front());
          void'(pend_due.pop_front());
        end else begin
          got_sum.push_back('1);
          late_err++;
        end
        got_last.push_back(res_last);
        got_cyc.push_back(cyc);
      end
      if (pend_due.size() > 0 && pend_due[0] < cyc) begin
        void'(pend_due.pop_front());
        void'(pend_sum.pop_front());
        late_err++;
      end
      if (done) done_log.push_back(cyc);
      if (busy && !s_ready) run_len++;
      else if (run_len != 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  // Reference: image and kernel as plain arrays, sums by direct convolution.
  logic [DW-1:0] kern [9];
  logic [DW-1:0] img  [W*H];
  logic [DW-1:0] exp_q [$];
  int            exp_addr [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_sum.delete(); got_last.delete(); got_cyc.delete();
    done_log.delete(); addr_log.delete(); runs.delete();
    run_len = 0; late_err = 0;
  endtask

  task automatic build_expect(input bit keep);
    logic [DW-1:0] s;
    exp_q.delete();
    exp_addr.delete();
    if (!keep) for (int k = 0; k < 9; k++) exp_addr.push_back(9 + k);
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        s = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s = s + img[(r-2+dr)*W + (c-2+dc)] * kern[dr*3+dc];
        exp_q.push_back(s);
        for (int j = 0; j < 9; j++) exp_addr.push_back(j);
      end
    end
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 1) return 3;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic push_word(input logic [DW-1:0] w, input int gap, input bit poke);
    int t;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = poke;
      tick();
    end
    start   = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        tick();
        break;
      end
      tick();
      t++;
      if (t > 100) begin
        `CHK("handshake_timeout", t, 0)
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic start_frame(input bit keep);
`ifdef KERNEL_PERSIST_EN
    keep_k = keep;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef KERNEL_PERSIST_EN
    keep_k = 1'b0;
`endif
  endtask

  task automatic check_frame();
    int n;
    `CHK("num_results", got_sum.size(), NWIN)
    n = (got_sum.size() < NWIN) ? got_sum.size() : NWIN;
    for (int i = 0; i < n; i++) begin
      `CHK("window_sum", got_sum[i], exp_q[i])
      `CHK("res_last", got_last[i], (i == NWIN-1))
    end
    `CHK("result_latency", late_err, 0)
    `CHK("done_pulses", done_log.size(), 1)
    if (done_log.size() > 0 && got_cyc.size() > 0)
      `CHK("done_after_last", done_log[0], got_cyc[got_cyc.size()-1] + 1)
    `CHK("write_count", addr_log.size(), exp_addr.size())
    n = (addr_log.size() < exp_addr.size()) ? addr_log.size() : exp_addr.size();
    for (int i = 0; i < n; i++) `CHK("write_addr", addr_log[i], exp_addr[i])
    `CHK("stall_runs", runs.size(), NWIN)
    n = (runs.size() < NWIN) ? runs.size() : NWIN;
    for (int i = 0; i < n; i++) `CHK("stall_len", runs[i], (i == NWIN-1) ? 9 + LAT : 9)
    `CHK("busy_after_done", busy, 1'b0)
  endtask

  // mode 0: back-to-back words, 1: 3-cycle gaps with start poked, 2: random gaps
  task automatic run_frame(input int mode, input bit keep);
    int t;
    clear_logs();
    build_expect(keep);
    start_frame(keep);
    if (!keep) for (int k = 0; k < 9; k++) push_word(kern[k], gap_for(mode), 1'b0);
    for (int p = 0; p < W*H; p++) push_word(img[p], gap_for(mode), mode == 1);
    t = 0;
    while (done_log.size() == 0 && t < 300) begin
      tick();
      t++;
    end
    tick();
    tick();
    check_frame();
  endtask

  task automatic check_reset_outputs(input string where);
    `CHK(where, s_ready, 1'b0)
    `CHK(where, conv_a, {DW{1'b0}})
    `CHK(where, conv_addr, PARK_A)
    `CHK(where, conv_en, 1'b0)
    `CHK(where, res_valid, 1'b0)
    `CHK(where, res_last, 1'b0)
    `CHK(where, busy, 1'b0)
    `CHK(where, done, 1'b0)
  endtask

  initial begin
    bit found;
    int t;

    repeat (3) tick();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    tick();

    // All-ones kernel over a 0..15 ramp.
    for (int k = 0; k < 9; k++) kern[k] = 32'd1;
    for (int p = 0; p < W*H; p++) img[p] = DW'(p);
    run_frame(0, 1'b0);

    // Centre-only kernel selects the middle pixel.
    for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 32'd1 : 32'd0;
    run_frame(2, 1'b0);

    // Abort in the middle of the first window emission.
    for (int k = 0; k < 9; k++) kern[k] = 32'd1;
    clear_logs();
    start_frame(1'b0);
    for (int k = 0; k < 9; k++) push_word(kern[k], 0, 1'b0);
    for (int p = 0; p <= 2*W + 2; p++) push_word(img[p], 0, 1'b0);
    found = 1'b0;
    t = 0;
    while (!found && t < 50) begin
      @(negedge clk);
      if (conv_addr == AW'(4)) found = 1'b1;
      else t++;
    end
    `CHK("reach_emit_tap4", found, 1'b1)
    rst = 1'b1;
    tick();
    check_reset_outputs("abort_state");
    tick();
    rst = 1'b0;
    repeat (30) tick();
    `CHK("no_result_after_abort", got_sum.size(), 0)
    `CHK("no_done_after_abort", done_log.size(), 0)
    run_frame(0, 1'b0);

    // Gapped input with start pulses while busy.
    run_frame(1, 1'b0);

    // Random kernels and images.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 9; k++) kern[k] = DW'($urandom_range(0, 255));
      for (int p = 0; p < W*H; p++) img[p] = DW'($urandom_range(0, 255));
      run_frame(2, 1'b0);
    end

`ifdef KERNEL_PERSIST_EN
    for (int k = 0; k < 9; k++) kern[k] = 32'd1;
    for (int p = 0; p < W*H; p++) img[p] = DW'(p);
    run_frame(0, 1'b0);
    run_frame(0, 1'b1);
    for (int p = 0; p < W*H; p++) img[p] = DW'($urandom_range(0, 255));
    run_frame(2, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

`undef CHK

endmodule
